// File: rtl/key_cmd_queue_if.sv
// Key-command bus between the key front end / processor side and key_cmd_queue.
// master drives key and ack inputs; slave (the queue) drives the read side.
interface key_cmd_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]           insn_key;
  logic                       key_pressed;
  logic [WIDTH-1:0]           insn_out;
  logic                       insn_valid;
  logic                       insn_ack;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;

  modport master (
    output insn_key, key_pressed, insn_ack,
    input  insn_out, insn_valid, count, overflow
  );

  modport slave (
    input  insn_key, key_pressed, insn_ack,
    output insn_out, insn_valid, count, overflow
  );
endinterface

// File: rtl/key_cmd_queue.sv
// Captures insn_key on each key press into a show-ahead FIFO drained by valid/ack.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module key_cmd_queue #(
  parameter int DEPTH         = 4,
  parameter int WIDTH         = 32,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic            clk_in,
  input  logic            reset_SW1,
  key_cmd_queue_if.slave  kif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_cfg
    $error("key_cmd_queue: illegal parameter combination");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             key_q;
  logic             overflow_q, overflow_d;
  logic             rpt_fire;
  logic             cap_req, push, pop;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  // Counter is non-zero only after a real press; a key held through reset never repeats.
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_per_q, rpt_per_d;

  always_comb begin
    rpt_fire  = 1'b0;
    rpt_cnt_d = rpt_cnt_q;
    rpt_per_d = rpt_per_q;
    if (!kif.key_pressed) begin
      rpt_cnt_d = '0;
      rpt_per_d = 1'b0;
    end else if (!key_q) begin
      rpt_cnt_d = RW'(1);
      rpt_per_d = 1'b0;
    end else if (rpt_cnt_q != '0) begin
      if (rpt_cnt_q == (rpt_per_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
        rpt_fire  = 1'b1;
        rpt_cnt_d = RW'(1);
        rpt_per_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_SW1) begin
    if (reset_SW1) begin
      rpt_cnt_q <= '0;
      rpt_per_q <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_per_q <= rpt_per_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    cap_req    = (kif.key_pressed & ~key_q) | rpt_fire;
    pop        = kif.insn_ack & (count_q != '0);
    push       = cap_req & ((count_q < CW'(DEPTH)) | pop);
    overflow_d = overflow_q | (cap_req & ~push);
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    // Head register: a word pushed into the new head slot bypasses the array.
    out_d = out_q;
    if (count_d != '0) begin
      out_d = (push && (wr_ptr_q == rd_ptr_d)) ? kif.insn_key : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= kif.insn_key;
    end
  end

  always_ff @(posedge clk_in or posedge reset_SW1) begin
    if (reset_SW1) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      key_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      key_q      <= kif.key_pressed;
      overflow_q <= overflow_d;
    end
  end

  assign kif.insn_out   = out_q;
  assign kif.insn_valid = (count_q != '0);
  assign kif.count      = count_q;
  assign kif.overflow   = overflow_q;
endmodule

// File: doc/key_cmd_queue.md
# key_cmd_queue

Receiving end of the key-command path. Captures one `insn_key` word on each press reported by the key front end and buffers it in a small FIFO. The processor drains the FIFO through a valid/ack handshake. The block sits between the key front end and the processor, so bursts of presses are not lost while the processor is busy.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, 2..16.
- `WIDTH`, 32, command word width.
- `REPEAT_DELAY`, 25000000, cycles a key must be held before the first auto-repeat (used only with `KEY_REPEAT_EN`).
- `REPEAT_PERIOD`, 5000000, cycles between subsequent auto-repeats (used only with `KEY_REPEAT_EN`).
- `clk_in`, in, 1, single clock; all logic on its rising edge.
- `reset_SW1`, in, 1, reset; asynchronous, active-high.
- `insn_key`, in, WIDTH, command word from the key front end; valid while `key_pressed` is high.
- `key_pressed`, in, 1, level; high while a key is held.
- `insn_out`, out, WIDTH, head-of-FIFO word (show-ahead).
- `insn_valid`, out, 1, FIFO non-empty.
- `insn_ack`, in, 1, consumer pops the head this cycle.
- `count`, out, $clog2(DEPTH)+1, current occupancy.
- `overflow`, out, 1, sticky flag: a capture was dropped.

## Operation
- Reset forces the following values. The reset is asynchronous and takes effect mid-operation; any in-flight contents are discarded.
  - read pointer = 0, write pointer = 0, `count` = 0
  - `insn_valid` = 0, `overflow` = 0, `insn_out` = 0
  - edge register `key_q` = 1, so a key held through reset release is not captured
  - repeat counter = 0
- Press detection:
  - `key_q` registers `key_pressed` every cycle.
  - A capture request occurs on any edge where `key_pressed`=1 and `key_q`=0.
  - `insn_key` is sampled on that edge.
- Push and pop:
  - A push occurs on a capture request when `count` < DEPTH, or when `count` = DEPTH and a pop occurs on the same edge.
  - A capture request under any other condition is dropped and sets `overflow`=1. `overflow` stays set until reset.
  - A pop occurs when `insn_ack`=1 and `insn_valid`=1. `insn_ack` while empty is ignored and causes no underflow.
  - Push and pop on the same edge leave `count` unchanged, and both pointers advance.
  - Pointers wrap modulo DEPTH.
- Read side:
  - `insn_out` always presents the entry at the read pointer.
  - When the FIFO is empty, `insn_out` holds its last value, or 0 after reset.
  - `insn_valid` = (`count` != 0).
- Width rule: `count` has one extra bit so that full (=DEPTH) is distinguishable from empty.

## Timing
- Capture latency: the edge that first sees `key_pressed`=1 with `key_q`=0 writes the FIFO. `insn_valid` and `insn_out` reflect the new entry in the cycle after that edge (one cycle).
- Pop latency: after the acknowledged edge, `insn_out` shows the next entry, or `insn_valid` drops if the FIFO is now empty.
- Consumer rule: the consumer may hold `insn_ack` high continuously, which pops one entry per cycle.
- `count`, `insn_valid` and `overflow` are registered outputs. No combinational path exists from inputs to outputs, except that `insn_out` follows the registered read pointer.
- A release followed by a re-press one cycle later is a new capture request. The block performs no debouncing; that is the front end's job.

## Configuration
- Macro: `KEY_REPEAT_EN`.
- Defined (auto-repeat enabled):
  - While `key_pressed` stays high after a capture, a repeat counter runs.
  - An additional capture request is generated REPEAT_DELAY cycles after the press edge, then every REPEAT_PERIOD cycles.
  - Each repeat samples the current `insn_key` and follows the same full/overflow rules as a press.
  - Release clears the counter; reset clears it.
- Undefined (auto-repeat compiled out): exactly one capture per press. `REPEAT_DELAY` and `REPEAT_PERIOD` are unused and no counter logic is synthesized.

## Test plan
- Single press: reset, then `key_pressed` rises with `insn_key`=32'h0000_0003 and no ack. The cycle after the edge must show `insn_valid`=1, `insn_out`=3, `count`=1. A single `insn_ack` must then give `insn_valid`=0, `count`=0.
- Fill and overflow: DEPTH=4, no acks, five presses with words 1..5. The bench must see `count`=4 and `overflow`=1. Four acks must return 1, 2, 3, 4 in order; word 5 is lost.
- Full with simultaneous pop: FIFO full with 1..4, then a press of word 9 on the same edge as an ack. The result must be `count`=4, `overflow`=0, and drained order 2, 3, 4, 9.
- Wrap-around: ten push/pop pairs through DEPTH=4. Output order must equal input order. Ack while empty must leave `count`=0 with no spurious valid.
- Reset mid-operation and held key: reset asserted with 3 entries queued and the key held. All outputs must go to 0 immediately. After release of reset with the key still held there is no capture; the next fresh press captures normally.
- With `KEY_REPEAT_EN`, REPEAT_DELAY=10, REPEAT_PERIOD=4: hold the key for 20 cycles. Captures must occur at edge 0, then +10, +14 and +18 (4 entries). Without the macro the same stimulus gives 1 entry.
